// File: rtl/lc3_pkg.sv
// Shared LC-3 datapath constants: word/register widths, NZP encodings and the
// writeback grant identifiers used by the regfile write-port arbiter.
package lc3_pkg;

  localparam int WORD_W = 16;
  localparam int REG_W  = 3;

  localparam logic [2:0] NZP_N = 3'b100;
  localparam logic [2:0] NZP_Z = 3'b010;
  localparam logic [2:0] NZP_P = 3'b001;

  typedef enum logic [0:0] {
    GNT_EX  = 1'b0,
    GNT_MEM = 1'b1
  } grant_e;

endpackage

// File: rtl/nzp_gen.sv
// Combinational condition-code generator: classifies a word as negative, zero
// or positive. Shared with the BR unit for its test compare.
module nzp_gen #(
  parameter int WORD_W = lc3_pkg::WORD_W
) (
  input  logic [WORD_W-1:0] i_word,
  output logic [2:0]        o_nzp
);
  import lc3_pkg::*;

  // Sign bit dominates, so exactly one code bit is ever set.
  always_comb begin
    o_nzp = NZP_P;
    if (i_word[WORD_W-1]) begin
      o_nzp = NZP_N;
    end else if (i_word == {WORD_W{1'b0}}) begin
      o_nzp = NZP_Z;
    end else begin
      o_nzp = NZP_P;
    end
  end

endmodule

// File: rtl/regfile_wb_arb.sv
// Round-robin arbiter between the execute and memory writeback requesters for
// the single regfile write port, with registered write triple and NZP register.
module regfile_wb_arb #(
  parameter int WORD_W = lc3_pkg::WORD_W,
  parameter int REG_W  = lc3_pkg::REG_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic [REG_W-1:0]  ex_dr,
  input  logic [WORD_W-1:0] ex_data,
  input  logic              ex_setcc,
  output logic              ex_ready,
  input  logic              mem_valid,
  input  logic [REG_W-1:0]  mem_dr,
  input  logic [WORD_W-1:0] mem_data,
  input  logic              mem_setcc,
  output logic              mem_ready,
  input  logic              wb_hold,
  output logic [REG_W-1:0]  dr_sel,
  output logic [WORD_W-1:0] dr_in,
  output logic              load_reg,
  output logic [2:0]        nzp,
  output logic              pend_valid,
  output logic [REG_W-1:0]  pend_dr
);
  import lc3_pkg::*;

  grant_e            r_last_grant;
  logic [REG_W-1:0]  r_dr_sel;
  logic [WORD_W-1:0] r_dr_in;
  logic              r_load_reg;
  logic [2:0]        r_nzp;

  logic              w_ex_ready;
  logic              w_mem_ready;
  logic              w_grant;
  logic [REG_W-1:0]  w_win_dr;
  logic [WORD_W-1:0] w_win_data;
  logic              w_win_setcc;
  logic [2:0]        w_win_nzp;

  // Grant decision: the requester not granted last time wins a contention.
  always_comb begin
    w_ex_ready  = 1'b0;
    w_mem_ready = 1'b0;
    if (rst || wb_hold) begin
      w_ex_ready  = 1'b0;
      w_mem_ready = 1'b0;
    end else if (ex_valid && mem_valid) begin
      w_ex_ready  = (r_last_grant == GNT_MEM);
      w_mem_ready = (r_last_grant == GNT_EX);
    end else begin
      w_ex_ready  = ex_valid;
      w_mem_ready = mem_valid;
    end
  end

  assign w_grant = w_ex_ready | w_mem_ready;

  // Route the winning requester's write toward the output stage.
  always_comb begin
    w_win_dr    = ex_dr;
    w_win_data  = ex_data;
    w_win_setcc = ex_setcc;
    if (w_mem_ready) begin
      w_win_dr    = mem_dr;
      w_win_data  = mem_data;
      w_win_setcc = mem_setcc;
    end else begin
      w_win_dr    = ex_dr;
      w_win_data  = ex_data;
      w_win_setcc = ex_setcc;
    end
  end

  nzp_gen #(
    .WORD_W (WORD_W)
  ) u_nzp_gen (
    .i_word (w_win_data),
    .o_nzp  (w_win_nzp)
  );

  // Output stage, condition codes and fairness pointer; index/data hold when idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_grant <= GNT_MEM;
      r_dr_sel     <= {REG_W{1'b0}};
      r_dr_in      <= {WORD_W{1'b0}};
      r_load_reg   <= 1'b0;
      r_nzp        <= NZP_Z;
    end else if (w_grant) begin
      r_last_grant <= w_mem_ready ? GNT_MEM : GNT_EX;
      r_dr_sel     <= w_win_dr;
      r_dr_in      <= w_win_data;
      r_load_reg   <= 1'b1;
      r_nzp        <= w_win_setcc ? w_win_nzp : r_nzp;
    end else begin
      r_load_reg   <= 1'b0;
    end
  end

  assign ex_ready   = w_ex_ready;
  assign mem_ready  = w_mem_ready;
  assign dr_sel     = r_dr_sel;
  assign dr_in      = r_dr_in;
  assign load_reg   = r_load_reg;
  assign nzp        = r_nzp;
  assign pend_valid = r_load_reg;
  assign pend_dr    = r_dr_sel;

endmodule

// File: tb/tb_regfile_wb_arb.sv
// Scoreboard bench for regfile_wb_arb: a negedge reference model predicts
// grants and queues expected writes; a monitor checks presented writes.
module tb_regfile_wb_arb;
  localparam int WORD_W = 16;
  localparam int REG_W  = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              ex_valid, ex_setcc, ex_ready;
  logic [REG_W-1:0]  ex_dr;
  logic [WORD_W-1:0] ex_data;
  logic              mem_valid, mem_setcc, mem_ready;
  logic [REG_W-1:0]  mem_dr;
  logic [WORD_W-1:0] mem_data;
  logic              wb_hold;
  logic [REG_W-1:0]  dr_sel, pend_dr;
  logic [WORD_W-1:0] dr_in;
  logic              load_reg, pend_valid;
  logic [2:0]        nzp;

  always #5 clk = ~clk;

  regfile_wb_arb #(.WORD_W(WORD_W), .REG_W(REG_W)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_dr(ex_dr), .ex_data(ex_data), .ex_setcc(ex_setcc), .ex_ready(ex_ready),
    .mem_valid(mem_valid), .mem_dr(mem_dr), .mem_data(mem_data), .mem_setcc(mem_setcc), .mem_ready(mem_ready),
    .wb_hold(wb_hold), .dr_sel(dr_sel), .dr_in(dr_in), .load_reg(load_reg), .nzp(nzp),
    .pend_valid(pend_valid), .pend_dr(pend_dr)
  );

  typedef struct packed {
    logic [2:0]  dr;
    logic [15:0] data;
    logic [2:0]  nzp;
  } wr_t;

  wr_t         exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          m_last;
  logic [2:0]  m_nzp;
  logic [2:0]  shown_nzp = 3'b010;
  logic [15:0] m_rf  [8];
  logic [15:0] obs_rf[8];
  bit          ex_acc, mem_acc;
  logic [2:0]  seen_nzp[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [2:0] ref_nzp(input logic [15:0] d);
    if ($signed(d) < 0) return 3'b100;
    else if (d == 16'd0) return 3'b010;
    else return 3'b001;
  endfunction

  // Reference model: decide the grant from the arbitration rules, queue the write.
  always @(negedge clk) begin
    bit exp_ex, exp_mem;
    ex_acc = 1'b0;
    mem_acc = 1'b0;
    exp_ex = 1'b0;
    exp_mem = 1'b0;
    if (rst) begin
      m_last = 1;
      m_nzp  = 3'b010;
      chk("ex_ready_in_reset", ex_ready, 0);
      chk("mem_ready_in_reset", mem_ready, 0);
    end else begin
      if (!wb_hold) begin
        if (ex_valid && mem_valid) begin
          if (m_last == 1) exp_ex = 1'b1; else exp_mem = 1'b1;
        end else begin
          exp_ex  = ex_valid;
          exp_mem = mem_valid;
        end
      end
      chk("ex_ready", ex_ready, exp_ex);
      chk("mem_ready", mem_ready, exp_mem);
      if (exp_ex) begin
        if (ex_setcc) m_nzp = ref_nzp(ex_data);
        exp_q.push_back('{dr: ex_dr, data: ex_data, nzp: m_nzp});
        m_rf[ex_dr] = ex_data;
        m_last = 0;
        ex_acc = 1'b1;
      end
      if (exp_mem) begin
        if (mem_setcc) m_nzp = ref_nzp(mem_data);
        exp_q.push_back('{dr: mem_dr, data: mem_data, nzp: m_nzp});
        m_rf[mem_dr] = mem_data;
        m_last = 1;
        mem_acc = 1'b1;
      end
    end
  end

  // Monitor: compare every presented write against the queued expectation.
  always @(posedge clk) begin
    wr_t e;
    #1;
    if (rst) begin
      exp_q.delete();
      shown_nzp = 3'b010;
      chk("load_reg_in_reset", load_reg, 0);
    end else if (load_reg) begin
      if (exp_q.size() == 0) begin
        chk("spurious_write", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("dr_sel", dr_sel, e.dr);
        chk("dr_in", dr_in, e.data);
        chk("nzp", nzp, e.nzp);
        chk("pend_valid", pend_valid, 1);
        chk("pend_dr", pend_dr, e.dr);
        shown_nzp = e.nzp;
        obs_rf[dr_sel] = dr_in;
      end
    end else begin
      chk("missing_write", exp_q.size(), 0);
      chk("pend_valid_idle", pend_valid, 0);
      chk("nzp_idle", nzp, shown_nzp);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
    if (ex_acc) ex_valid = 1'b0;
    if (mem_acc) mem_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && (ex_valid || mem_valid); i++) cyc();
    chk("drain_timeout", {31'd0, ex_valid | mem_valid}, 0);
    cyc();
    cyc();
  endtask

  task automatic set_ex(input logic [2:0] dr, input logic [15:0] d, input logic cc);
    ex_valid = 1'b1; ex_dr = dr; ex_data = d; ex_setcc = cc;
  endtask

  task automatic set_mem(input logic [2:0] dr, input logic [15:0] d, input logic cc);
    mem_valid = 1'b1; mem_dr = dr; mem_data = d; mem_setcc = cc;
  endtask

  function automatic logic [15:0] rnd_data();
    case ($urandom_range(0, 3))
      0: return 16'd0;
      1: return 16'h8000 | 16'($urandom_range(0, 32767));
      default: return 16'($urandom_range(0, 65535));
    endcase
  endfunction

  initial begin
    ex_valid = 1'b0; ex_dr = 3'd0; ex_data = 16'd0; ex_setcc = 1'b0;
    mem_valid = 1'b0; mem_dr = 3'd0; mem_data = 16'd0; mem_setcc = 1'b0;
    wb_hold = 1'b0;
    for (int i = 0; i < 8; i++) begin
      m_rf[i] = 16'd0;
      obs_rf[i] = 16'd0;
    end
    #23 rst = 1'b0;
    cyc();
    cyc();
    chk("post_reset_nzp", nzp, 3'b010);
    chk("post_reset_load_reg", load_reg, 0);
    chk("post_reset_dr_sel", dr_sel, 0);
    chk("post_reset_dr_in", dr_in, 0);

    // Contention: EX wins first after reset, then strict alternation.
    set_ex(3'd1, 16'd0, 1'b1);
    set_mem(3'd2, 16'd5, 1'b1);
    for (int i = 0; i < 4; i++) begin
      ex_valid = 1'b1;
      mem_valid = 1'b1;
      cyc();
      seen_nzp[i] = nzp;
      chk("contention_dr", dr_sel, (i % 2 == 0) ? 3'd1 : 3'd2);
    end
    ex_valid = 1'b0;
    mem_valid = 1'b0;
    chk("contention_nzp0", seen_nzp[0], 3'b010);
    chk("contention_nzp1", seen_nzp[1], 3'b001);
    chk("contention_nzp2", seen_nzp[2], 3'b010);
    chk("contention_nzp3", seen_nzp[3], 3'b001);
    cyc();

    // Write of zero without setcc leaves nzp at 001.
    set_ex(3'd5, 16'd0, 1'b0);
    cyc();
    chk("nosetcc_load", load_reg, 1);
    chk("nosetcc_data", dr_in, 16'd0);
    chk("nosetcc_nzp", nzp, 3'b001);
    cyc();

    // Hold blocks the memory request for three cycles.
    wb_hold = 1'b1;
    set_mem(3'd6, 16'h1234, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("hold_load_reg", load_reg, 0);
      chk("hold_dr_in", dr_in, 16'd0);
    end
    wb_hold = 1'b0;
    cyc();
    chk("hold_release_load", load_reg, 1);
    chk("hold_release_dr", dr_sel, 3'd6);
    chk("hold_release_data", dr_in, 16'h1234);
    cyc();

    // Same destination from both units: 7 then 9 into R4.
    set_ex(3'd4, 16'd7, 1'b0);
    set_mem(3'd4, 16'd9, 1'b0);
    cyc();
    chk("samedst_first", dr_in, 16'd7);
    cyc();
    chk("samedst_second", dr_in, 16'd9);
    cyc();
    chk("samedst_final_r4", obs_rf[4], 16'd9);

    // Single EX write with a negative result.
    set_ex(3'd3, 16'hFFFE, 1'b1);
    cyc();
    chk("single_load", load_reg, 1);
    chk("single_dr", dr_sel, 3'd3);
    chk("single_data", dr_in, 16'hFFFE);
    chk("single_nzp", nzp, 3'b100);
    cyc();

    // Mid-operation asynchronous reset.
    set_ex(3'd2, 16'h0042, 1'b1);
    set_mem(3'd7, 16'h8001, 1'b1);
    cyc();
    #1 rst = 1'b1;
    #1;
    chk("async_rst_load", load_reg, 0);
    chk("async_rst_dr_sel", dr_sel, 0);
    chk("async_rst_dr_in", dr_in, 0);
    chk("async_rst_nzp", nzp, 3'b010);
    chk("async_rst_ex_ready", ex_ready, 0);
    chk("async_rst_mem_ready", mem_ready, 0);
    ex_valid = 1'b0;
    mem_valid = 1'b0;
    #15 rst = 1'b0;
    cyc();
    cyc();
    set_mem(3'd7, 16'h8001, 1'b1);
    drain();

    // Randomized traffic with occasional hold.
    for (int n = 0; n < 400; n++) begin
      if (!ex_valid && $urandom_range(0, 99) < 60)
        set_ex(3'($urandom_range(0, 7)), rnd_data(), 1'($urandom_range(0, 1)));
      if (!mem_valid && $urandom_range(0, 99) < 60)
        set_mem(3'($urandom_range(0, 7)), rnd_data(), 1'($urandom_range(0, 1)));
      wb_hold = ($urandom_range(0, 99) < 15);
      cyc();
    end
    wb_hold = 1'b0;
    drain();
    for (int i = 0; i < 8; i++) chk("final_regfile", obs_rf[i], m_rf[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arb.md
# regfile_wb_arb

Write-port arbiter and condition-code unit for the LC-3 register file. Two writeback requesters, the execute unit (ALU/LEA results) and the memory unit (LD/LDR/LDI results), compete for the single regfile write port. The block grants one per cycle with round-robin fairness and drives a registered `dr_sel`/`dr_in`/`load_reg` triple into the regfile. It also maintains the NZP condition-code register and exposes the in-flight write for decode hazard checks.

## Interface
Parameters:
- `WORD_W`, 16, data word width
- `REG_W`, 3, register index width (8 GPRs)

Ports:
- `clk`  in  1  system clock, all state on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `ex_valid`  in  1  execute unit has a result to write
- `ex_dr`  in  REG_W  execute destination register
- `ex_data`  in  WORD_W  execute result
- `ex_setcc`  in  1  execute result updates NZP
- `ex_ready`  out  1  execute request accepted this cycle
- `mem_valid` / `mem_dr` / `mem_data` / `mem_setcc` / `mem_ready`: same as `ex_*`, for the memory unit
- `wb_hold`  in  1  control FSM freeze; no grant while high
- `dr_sel`  out  REG_W  regfile write index (registered)
- `dr_in`  out  WORD_W  regfile write data (registered)
- `load_reg`  out  1  regfile write enable (registered)
- `nzp`  out  3  condition codes {N,Z,P}
- `pend_valid`  out  1  a write is presented to the regfile this cycle (equals `load_reg`)
- `pend_dr`  out  REG_W  destination of that write (equals `dr_sel`)

## Operation
- Handshake: a transfer occurs when `x_valid && x_ready`. The requester holds `valid`, `dr`, `data` and `setcc` stable until accepted. `x_ready` is combinational from the valids, `wb_hold` and `last_grant`; it never depends on itself.
- Arbitration, when `wb_hold` = 0:
  - Only one requester valid: that requester is granted.
  - Both valid: the requester not in `last_grant` is granted.
  - Neither valid: no grant.
- `wb_hold` = 1: both readies are 0; `load_reg` is 0 in the next cycle.
- `last_grant` (1 bit: 0 = EX, 1 = MEM) updates only on an actual grant.
- Output stage, at the edge ending a granted cycle: `dr_sel` <= winner `dr`, `dr_in` <= winner `data`, `load_reg` <= 1. After a cycle with no grant, `load_reg` <= 0 and `dr_sel`/`dr_in` hold their values.
- NZP: on the same edge, if the winner's `setcc` = 1, then `nzp` <= 100 if `data[15]`, 010 if `data == 0`, else 001. Exactly one bit is ever set. If `setcc` = 0, `nzp` holds.
- Same `dr` requested by both units in the same cycle: both writes occur on consecutive cycles in round-robin order; the later one wins in the regfile. No merging.
- Reset values: `load_reg` 0, `dr_sel` 0, `dr_in` 0, `nzp` 010, `last_grant` 1 (MEM), so EX wins the first contention. Readies are 0 while `rst` is high.
- Reset asserted mid-operation clears the output stage asynchronously. An accepted write not yet presented is discarded, and requesters re-present after reset.

## Timing
- Latency: acceptance in cycle N gives `load_reg` = 1 during cycle N+1. The regfile commits at the rising edge ending N+1.
- `nzp` reflects a write from cycle N+1 onward, the same cycle the write is presented.
- Throughput: one write per cycle, no bubbles under back-to-back grants.
- Under continuous contention, grants alternate EX, MEM, EX, … with the maximum wait per requester of 1 cycle.
- `pend_valid`/`pend_dr` are valid in cycle N+1. Decode treats `pend_dr` as not yet readable that cycle.

## Structure
- Shared `lc3_pkg`: `WORD_W`, `REG_W`, NZP encodings (`NZP_N` = 100, `NZP_Z` = 010, `NZP_P` = 001), grant enum (`GNT_EX`, `GNT_MEM`).
- One sub-module, `nzp_gen`: combinational, word in, 3-bit NZP out. It is reused by the BR unit for test compare.
- Top level holds the arbiter logic, `last_grant`, output registers and the `nzp` register.

## Test plan
- Reset: assert `rst` mid-cycle -> outputs clear immediately; after release `nzp` = 010, `load_reg` = 0, both readies 0 until a valid arrives.
- Single EX write: `ex_valid` = 1, `ex_dr` = 3, `ex_data` = 16'hFFFE, `setcc` = 1 -> `ex_ready` = 1 in cycle N; cycle N+1 shows `load_reg` = 1, `dr_sel` = 3, `dr_in` = FFFE, `nzp` = 100.
- Contention: both valid for 4 cycles (`ex_data` = 0 to R1, `mem_data` = 5 to R2, both `setcc`) -> grants EX, MEM, EX, MEM; `nzp` sequence 010, 001, 010, 001.
- Same destination: EX writes 7, MEM writes 9, both to R4, simultaneously -> R4 is written 7 then 9; final R4 = 9.
- Hold: `wb_hold` = 1 for 3 cycles with `mem_valid` = 1 -> `mem_ready` = 0 and `load_reg` = 0 throughout; first grant in the cycle `wb_hold` drops; data is unchanged.
- `setcc` = 0: load value 0 with `setcc` = 0 after `nzp` = 001 -> register written, `nzp` stays 001.
